// File: rtl/add_sequencer.sv
// add_sequencer: W-bit (W = N*M) adder built from one shared N-bit adder.
// The adder handles one N-bit chunk per cycle, least significant chunk first.
// The carry between chunks is held in a register.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set on a/b/carry_in is valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       W-bit operands (unsigned or two's complement)
//   carry_in   carry into chunk 0
//   out_valid  sum/carry_out/ovf valid (DONE and not in reset)
//   out_ready  consumer accepts the result
//   sum        registered W-bit sum
//   carry_out  carry out of the MSB chunk
//   ovf        signed overflow of the W-bit addition
//   busy       high while chunks are being added (RUN)

module adder_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

module add_sequencer #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*M-1:0] a,
    input  logic [N*M-1:0] b,
    input  logic           carry_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*M-1:0] sum,
    output logic           carry_out,
    output logic           ovf,
    output logic           busy
);

    localparam int W  = N * M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  a_chunk, b_chunk, add_sum;
    logic          add_cout;
    logic          last_chunk;

    assign a_chunk    = a_q[cnt_q*N +: N];
    assign b_chunk    = b_q[cnt_q*N +: N];
    assign last_chunk = (cnt_q == CW'(M - 1));

    adder_Nbit #(.N(N)) u_adder (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Handshake flags are gated by rst so that nothing is offered or accepted
    // during the reset cycle, even though the state register only clears on the edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == RUN)  && !rst;
    assign out_valid = (state_q == DONE) && !rst;

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q*N +: N] = add_sum;
                carry_d             = add_cout;
                if (last_chunk) begin
                    // The counter is parked at 0 so the chunk index never points past the operand.
                    cnt_d   = '0;
                    state_d = DONE;
                    cout_d  = add_cout;
                    // add_sum[N-1] is the new sum MSB on the final chunk.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
